inst_axi_bridge: RTL
====================

Name: inst_axi_bridge

Overview:
- Upstream of the fetch stage: converts the fetch stage's split-handshake instruction request (req_valid / addr_ok / data_ok) into single-beat AXI4 read transactions.
- Tracks up to MAX_OUTSTANDING in-order reads, so the fetch stage can issue the next address before the previous data returns.
- Returns each 64-bit beat as a one-cycle data_ok pulse with rdata; the fetch stage selects the 32-bit half itself.

Parameters:
ADDR_W, 64, request/AXI address width
DATA_W, 64, data width
MAX_OUTSTANDING, 2, max accepted-but-unreturned reads (1..3)
AXI_ID, 0, constant ar_id value

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  fetch request valid
req_op  in  1  0=read; 1 is illegal for this port
req_addr  in  ADDR_W  fetch byte address
addr_ok  out  1  request accepted this cycle (combinational)
data_ok  out  1  one-cycle pulse, rdata valid
rdata  out  DATA_W  returned beat, registered
bus_err  out  1  sticky: non-OKAY r_resp, unexpected R beat, or req_op=1 accepted
ar_valid  out  1  AXI read address valid
ar_ready  in  1  AXI read address ready
ar_addr  out  ADDR_W  8-byte aligned address
ar_id  out  4  = AXI_ID
ar_len  out  8  = 0
ar_size  out  3  = 3'b011
ar_burst  out  2  = 2'b01
r_valid  in  1  AXI read data valid
r_ready  out  1  AXI read data ready
r_data  in  DATA_W  AXI read data
r_resp  in  2  AXI read response
r_last  in  1  AXI last beat (must be 1)

Behaviour:
- Reset (rst=1 at posedge): AR FSM=AR_IDLE, ar_valid=0, ar_addr=0, cnt=0, data_ok=0, rdata=0, bus_err=0. r_ready=0 while rst. A reset mid-transaction drops all outstanding reads without completing them; R beats arriving afterwards with cnt=0 set bus_err.
- cnt: 2-bit count of accepted, unreturned reads.
- AR FSM AR_IDLE:
  - addr_ok = req_valid & ~rst & (cnt < MAX_OUTSTANDING).
  - On addr_ok: ar_addr <= {req_addr[ADDR_W-1:3], 3'b0}, ar_valid <= 1, go to AR_WAIT.
- AR FSM AR_WAIT:
  - addr_ok=0; ar_valid=1 and ar_addr held stable until ar_ready.
  - On ar_valid & ar_ready: ar_valid <= 0, go to AR_IDLE.
  - Next addr_ok is possible the cycle after the AR handshake, giving a minimum of 2 cycles per request.
- cnt increments on addr_ok and decrements on an R handshake (r_valid & r_ready). Both in the same cycle leaves cnt unchanged. cnt never exceeds MAX_OUTSTANDING.
- r_ready = ~rst & (cnt != 0). There is no backpressure from fetch, which always absorbs data_ok.
- R handshake: next cycle data_ok=1 and rdata=r_data (latency 1 from r_valid). rdata holds its value until the next handshake. data_ok is 0 otherwise.
- Errors:
  - r_resp != 2'b00 → bus_err <= 1; data_ok still pulses with r_data.
  - r_valid with cnt==0 → beat ignored, bus_err <= 1.
  - r_last=0 on a beat → bus_err <= 1.
  - addr_ok with req_op=1 → bus_err <= 1; the read is still issued.
  - bus_err clears only on rst.
- Ordering: single ID, so AXI returns beats in order and data_ok pulses occur in request order.
- Address accepted and data returned in the same cycle for different requests is legal: addr_ok and the R handshake proceed independently.

Decomposition:
- Shared defines: AXI_SIZE_8B=3'b011, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, AR FSM state encodings (AR_IDLE=1'b0, AR_WAIT=1'b1).
- The AR channel FSM and the outstanding counter live in the top module; no sub-module is needed.
- A data-side sibling would reuse the same defines.

Test Plan:
- Single read: req_addr=0x8000_0004, ar_ready=1, then r_valid 3 cycles later with r_data=0x11223344_55667788 → addr_ok 1 cycle, ar_addr=0x8000_0000, data_ok pulses 1 cycle after the R handshake, rdata=0x1122334455667788, cnt returns to 0.
- Back-pressure: ar_ready held 0 for 4 cycles → ar_valid stays 1 with ar_addr stable, addr_ok=0 throughout, handshake on cycle 5.
- Outstanding limit: req_valid held 1, ar_ready=1, no R → exactly 2 addr_ok pulses, then addr_ok=0 with cnt=2. Two R beats 0xA, 0xB → data_ok pulses in order carrying 0xA then 0xB, cnt=0.
- Simultaneous accept and return: cnt=1 with addr_ok and an R handshake in the same cycle → cnt stays 1, and both the ar_valid assertion and the data_ok pulse occur.
- Errors: r_resp=2'b10 → data_ok pulses and bus_err=1 sticky. Separately, r_valid with cnt=0 after reset → no data_ok and bus_err=1.
- Reset mid-operation: rst asserted while in AR_WAIT with cnt=2 → next cycle ar_valid=0, cnt=0, data_ok=0, bus_err=0, and a later fresh request works normally.

Source files
------------

// File: rtl/inst_axi_bridge_pkg.sv
// Shared AXI read-channel constants and AR FSM encodings.
// Used by the instruction bridge and any data-side sibling.
package inst_axi_bridge_pkg;

    // Default widths for the fetch/AXI bundle.
    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;

    // Fixed AXI encodings for single-beat 64-bit reads.
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [7:0] AXI_LEN_1BEAT  = 8'd0;

    // Address channel state: idle, or holding ar_valid until ar_ready.
    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_WAIT = 1'b1
    } ar_state_e;

    // Per-cycle error causes, OR-ed into the sticky bus_err.
    typedef struct packed {
        logic resp_err;
        logic stray_beat;
        logic no_last;
        logic bad_op;
    } err_flags_t;

endpackage

// File: rtl/inst_axi_bridge_if.sv
// Fetch request/response bundle plus AXI AR and R channels.
// master = bridge side, slave = fetch stage + AXI fabric side.
interface inst_axi_bridge_if
    import inst_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              req_valid;
    logic              req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;
    logic              bus_err;

    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [3:0]        ar_id;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;

    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;

    modport master (
        input  req_valid, req_op, req_addr,
        output addr_ok, data_ok, rdata, bus_err,
        output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_last,
        output r_ready
    );

    modport slave (
        output req_valid, req_op, req_addr,
        input  addr_ok, data_ok, rdata, bus_err,
        input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        output ar_ready,
        output r_valid, r_data, r_resp, r_last,
        input  r_ready
    );

endinterface

// File: rtl/inst_axi_bridge.sv
// Fetch-side split handshake to single-beat AXI4 reads.
// Keeps up to MAX_OUTSTANDING in-order reads in flight.
module inst_axi_bridge
    import inst_axi_bridge_pkg::*;
#(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 2,
    parameter int AXI_ID          = 0
) (
    input logic               clk,
    input logic               rst,
    inst_axi_bridge_if.master bus
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

    ar_state_e         state_q;
    ar_state_e         state_d;
    logic              ar_valid_q;
    logic              ar_valid_d;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [ADDR_W-1:0] ar_addr_d;

    logic [1:0]        cnt;
    logic [1:0]        cnt_d;

    logic              accept;
    logic              ar_hs;
    logic              r_rdy;
    logic              r_hs;

    logic              data_ok_q;
    logic [DATA_W-1:0] rdata_q;
    logic              bus_err_q;
    err_flags_t        err;

    // The low address bits only select bytes within the 8-byte beat.
    logic              unused_addr_lsb;
    assign unused_addr_lsb = ^bus.req_addr[2:0];

    // Accept only in idle, out of reset, and with room in the counter.
    assign accept = bus.req_valid & ~rst
                  & (state_q == AR_IDLE)
                  & (cnt < MAX_CNT);

    assign ar_hs = ar_valid_q & bus.ar_ready;

    // Any accepted read may return, so ready tracks a non-zero count.
    assign r_rdy = ~rst & (cnt != 2'd0);
    assign r_hs  = bus.r_valid & r_rdy;

    // AR channel next-state: latch aligned address, hold until ready.
    always_comb begin
        state_d    = state_q;
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        unique case (state_q)
            AR_IDLE: begin
                if (accept) begin
                    ar_addr_d  = {bus.req_addr[ADDR_W-1:3], 3'b000};
                    ar_valid_d = 1'b1;
                    state_d    = AR_WAIT;
                end
            end
            AR_WAIT: begin
                if (ar_hs) begin
                    ar_valid_d = 1'b0;
                    state_d    = AR_IDLE;
                end
            end
        endcase
    end

    // Outstanding count: +1 on accept, -1 on R handshake, both = hold.
    always_comb begin
        cnt_d = cnt;
        unique case ({accept, r_hs})
            2'b10:   cnt_d = cnt + 2'd1;
            2'b01:   cnt_d = cnt - 2'd1;
            default: cnt_d = cnt;
        endcase
    end

    // Error causes observed this cycle.
    always_comb begin
        err            = '0;
        err.resp_err   = r_hs & (bus.r_resp != AXI_RESP_OKAY);
        err.stray_beat = bus.r_valid & (cnt == 2'd0);
        err.no_last    = r_hs & ~bus.r_last;
        err.bad_op     = accept & bus.req_op;
    end

    // AR FSM state and address channel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= AR_IDLE;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
        end
    end

    // Outstanding read counter; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 2'd0;
        end else begin
            cnt <= cnt_d;
        end
    end

    // Return path: one-cycle data_ok, rdata held until next beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            data_ok_q <= r_hs;
            if (r_hs) begin
                rdata_q <= bus.r_data;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else if (|err) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus.addr_ok  = accept;
    assign bus.data_ok  = data_ok_q;
    assign bus.rdata    = rdata_q;
    assign bus.bus_err  = bus_err_q;

    assign bus.ar_valid = ar_valid_q;
    assign bus.ar_addr  = ar_addr_q;
    assign bus.ar_id    = 4'(AXI_ID);
    assign bus.ar_len   = AXI_LEN_1BEAT;
    assign bus.ar_size  = AXI_SIZE_8B;
    assign bus.ar_burst = AXI_BURST_INCR;

    assign bus.r_ready  = r_rdy;

endmodule
